// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller slice: controller phase
// encodings, instruction field positions and road count.
package tlc_pkg;

    typedef enum logic [1:0] {
        SLOT = 2'd0,
        NORM = 2'd1,
        INT  = 2'd2
    } phase_t;

    localparam int INSTR_INT_BIT   = 2;
    localparam int INSTR_ROAD_MSB  = 1;
    localparam int NUM_ROADS       = 4;
    localparam int DEFAULT_INT_LEN = 5;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_ROADS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROADS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker: the first set request at or above
// ptr (wrapping 3 -> 0) wins.
module rr_arbiter4
    import tlc_pkg::*;
(
    input  logic [NUM_ROADS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_ROADS-1:0] gnt,
    output logic                 any
);

    // rot[i] is the request i places after the pointer
    logic [NUM_ROADS-1:0] rot;

    for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_rot
        assign rot[gi] = req[ptr + 2'(gi)];
    end

    always_comb begin
        gnt = '0;
        for (int i = NUM_ROADS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt              = '0;
                gnt[ptr + 2'(i)] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/emergency_request_scheduler.sv
// Latches per-road ambulance requests and issues them round-robin into the light
// controller's fetch slots. Optional stale-request dropping: EMR_DROP_STALE_EN.
module emergency_request_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GAP = 2,
    parameter int INT_LEN = DEFAULT_INT_LEN
`ifdef EMR_DROP_STALE_EN
    ,
    parameter int STALE_SLOTS = 15
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_ROADS-1:0] req,
    input  logic                 enable,
    output logic                 valid,
    output logic [2:0]           instruction,
    output logic [NUM_ROADS-1:0] grant,
    output logic [NUM_ROADS-1:0] pending,
    output logic                 busy
`ifdef EMR_DROP_STALE_EN
    ,
    output logic [NUM_ROADS-1:0] dropped
`endif
);

    localparam int GAP_W = $clog2(MIN_GAP + 2);
    localparam int INT_W = $clog2(INT_LEN + 1);

    phase_t               phase_reg;
    logic [INT_W-1:0]     int_cnt_reg;
    logic [GAP_W-1:0]     gap_reg;
    logic [1:0]           ptr_reg;
    logic [NUM_ROADS-1:0] pending_reg;
    logic [NUM_ROADS-1:0] pending_next;
    logic [NUM_ROADS-1:0] clear_mask;
    logic [NUM_ROADS-1:0] grant_reg;
    logic [2:0]           instr_reg;
    logic [2:0]           instr_next;
    logic                 valid_reg;
    logic                 busy_reg;

    logic [NUM_ROADS-1:0] arb_req;
    logic [NUM_ROADS-1:0] arb_gnt;
    logic                 arb_any;
    logic [1:0]           road_sel;
    logic                 slot_edge;
    logic                 issue;

    // Requests arriving on the deciding edge take part in that decision.
    assign arb_req = pending_reg | req;

    rr_arbiter4 u_arb (
        .req (arb_req),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    assign road_sel  = onehot_to_idx(arb_gnt);
    assign slot_edge = (phase_reg == NORM) ||
                       ((phase_reg == INT) && (int_cnt_reg == INT_W'(1)));
    assign issue     = slot_edge && enable && arb_any && (gap_reg == '0);

    always_comb begin
        instr_next                   = '0;
        instr_next[INSTR_INT_BIT]    = 1'b1;
        instr_next[INSTR_ROAD_MSB:0] = road_sel;
    end

`ifdef EMR_DROP_STALE_EN
    logic [NUM_ROADS-1:0] drop_mask;
    logic [NUM_ROADS-1:0] dropped_reg;

    assign clear_mask = ((phase_reg == SLOT) ? grant_reg : '0) | drop_mask;

    for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_age
        logic [3:0] age_reg;
        logic       kept;

        assign kept          = pending_reg[gi] & ~clear_mask[gi];
        // A grant in the same slot takes precedence over the drop.
        assign drop_mask[gi] = (phase_reg == SLOT) && pending_reg[gi] && !grant_reg[gi] &&
                               (age_reg >= 4'(STALE_SLOTS - 1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                age_reg <= '0;
            end else if (req[gi] && !kept) begin
                age_reg <= '0;
            end else if ((phase_reg == SLOT) && kept) begin
                age_reg <= age_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dropped_reg <= '0;
        else       dropped_reg <= drop_mask;
    end

    assign dropped = dropped_reg;
`else
    assign clear_mask = (phase_reg == SLOT) ? grant_reg : '0;
`endif

    // Set wins: a fresh pulse on a road being cleared re-latches it.
    assign pending_next = (pending_reg & ~clear_mask) | req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg   <= SLOT;
            int_cnt_reg <= '0;
            gap_reg     <= '0;
            ptr_reg     <= '0;
            pending_reg <= '0;
            grant_reg   <= '0;
            instr_reg   <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            valid_reg   <= 1'b0;
            grant_reg   <= '0;
            instr_reg   <= '0;

            case (phase_reg)
                SLOT: begin
                    if (valid_reg) begin
                        phase_reg   <= INT;
                        int_cnt_reg <= INT_W'(INT_LEN);
                        busy_reg    <= 1'b1;
                    end else begin
                        phase_reg <= NORM;
                    end
                end
                NORM: phase_reg <= SLOT;
                INT: begin
                    if (int_cnt_reg == INT_W'(1)) begin
                        phase_reg <= SLOT;
                        busy_reg  <= 1'b0;
                    end else begin
                        int_cnt_reg <= int_cnt_reg - INT_W'(1);
                    end
                end
                default: begin
                    phase_reg <= SLOT;
                    busy_reg  <= 1'b0;
                end
            endcase

            if (slot_edge) begin
                if (issue) begin
                    valid_reg <= 1'b1;
                    instr_reg <= instr_next;
                    grant_reg <= arb_gnt;
                    ptr_reg   <= road_sel + 2'd1;
                    gap_reg   <= GAP_W'(MIN_GAP);
                end else if (gap_reg != '0) begin
                    gap_reg <= gap_reg - GAP_W'(1);
                end
            end
        end
    end

    assign valid       = valid_reg;
    assign instruction = instr_reg;
    assign grant       = grant_reg;
    assign pending     = pending_reg;
    assign busy        = busy_reg;

endmodule

// File: doc/emergency_request_scheduler.md
Name: emergency_request_scheduler

Overview:
- Collects ambulance-approach requests from four per-road sensors and sequences them into the traffic light controller's `valid`/`instruction[2:0]` fetch interface.
- The controller has no ready output, so this block keeps a phase model of the controller's FETCH cadence. It drives `valid` only in the controller's fetch cycles.
- Pending requests are shared round-robin, with a programmable minimum gap of normal cycles between ambulance interrupts.
- Sits between the road sensor front-end and the traffic light controller; both share `clk` and `reset`.

Parameters:
- MIN_GAP, 2, number of normal fetch slots that must pass after an interrupt before the next grant (0 allows back-to-back grants).
- INT_LEN, 5, non-fetch cycles the controller spends per interrupt (store, all-red, ambulance, recovery, restore).
- STALE_SLOTS, 15, fetch slots a request may stay pending before being dropped (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  per-road request pulse; bit n = ambulance approaching road n
- enable  input  1  1 = grants allowed; 0 = requests still latch but no grant is issued
- valid  output  1  to controller; instruction is valid this cycle
- instruction  output  3  to controller; bit2 = interrupt (always 1 when valid), bits[1:0] = ambulance road
- grant  output  4  one-hot pulse, high in the cycle the matching request is issued
- pending  output  4  latched outstanding requests
- busy  output  1  high while the controller is inside an interrupt sequence
- dropped  output  4  one-hot pulse on stale drop (present only when EMR_DROP_STALE_EN is defined)

Behaviour:
- Clock and reset: `reset` is asynchronous and active-high; clock is `clk`.
- Reset values:
  - `valid=0`, `instruction=3'b000`, `grant=0`, `pending=0`, `busy=0`, `dropped=0`.
  - Round-robin pointer = 0, gap counter = 0, phase = SLOT.
  - The first cycle after reset release is a controller fetch cycle.
- Phase FSM, mirroring the controller:
  - SLOT: the controller is in its fetch cycle.
    - If `valid=1` in SLOT: go to INT and load the interrupt counter with INT_LEN.
    - Otherwise go to NORM.
  - NORM: one cycle, then SLOT.
  - INT: count INT_LEN cycles with `busy=1`, then SLOT.
- Request latching:
  - Every cycle, `pending |= req`.
  - The bit for the granted road clears at the end of its SLOT cycle.
  - If `req[g]` is high in the same cycle that `pending[g]` clears, set wins: the bit stays 1 as a new request.
  - Repeated pulses on an already-pending road coalesce into one request.
- Grant decision:
  - Made on the clock edge entering SLOT, using `pending | req` sampled on that edge.
  - Grant only if `enable=1`, at least one pending bit is set, and the gap counter is 0.
  - Road chosen round-robin, searching upward from the pointer with wrap from 3 to 0. The pointer then becomes `g+1` (mod 4).
- Outputs are registered:
  - `valid=1`, `instruction={1'b1, g}` and `grant[g]=1` hold for exactly the SLOT cycle.
  - All three are 0 in every other cycle.
  - `valid` is never asserted outside SLOT.
- Gap counter:
  - Loaded with MIN_GAP when a grant issues.
  - Decrements by 1 on each SLOT that issues no grant, saturating at 0.
- `enable` low: requests accumulate and the phase model keeps running; the gap counter still decrements.
- Reset mid-interrupt: everything returns to reset values. Because the controller is reset at the same time, the phase model stays aligned.

Optional Feature:
- Macro EMR_DROP_STALE_EN.
- When defined:
  - Each road has a 4-bit age counter, cleared when the request is latched and incremented each SLOT while pending.
  - When a pending road reaches STALE_SLOTS and is not granted in that SLOT, its pending bit clears and `dropped[n]` pulses for 1 cycle.
  - If a grant and a drop would hit the same road in the same SLOT, the grant wins.
- When undefined: the `dropped` port, the age counters and the drop logic are absent, and requests wait indefinitely.

Decomposition:
- Package `tlc_pkg`:
  - phase encodings SLOT/NORM/INT
  - INSTR_INT_BIT = 2, INSTR_ROAD_MSB = 1, NUM_ROADS = 4
  - default INT_LEN = 5
- Sub-module `rr_arbiter4`: combinational 4-way round-robin pick from request vector and pointer, returning a one-hot grant and an any-request flag.

Test Plan:
- Release reset, pulse `req=0100` at cycle 3 → `valid=1`, `instruction=3'b110`, `grant=0100` in the next SLOT cycle; `busy=1` for the following 5 cycles; next SLOT 6 cycles after the grant.
- `req=1111` at once, MIN_GAP=0 → grants in order road 0, 1, 2, 3, each 6 cycles apart; `pending` goes 1111 → 1110 → 1100 → 1000 → 0000.
- MIN_GAP=2, `req=0011` → road 0 granted, then 2 SLOTs with `valid=0` (one per 2 cycles), then road 1 granted.
- `enable=0`, pulse `req=1000` → `pending=1000` held and `valid` stays 0; raise `enable` → grant on road 3 at the next SLOT.
- Re-pulse `req[1]` in the same cycle road 1's grant clears → `pending[1]` stays 1 and road 1 is granted again later.
- With EMR_DROP_STALE_EN, `enable=0` and `req=0001` → `dropped=0001` pulses after 15 SLOTs and `pending` returns to 0000.
